// File: rtl/cordic_pkg.sv
// ---------------------------------------------------------------------------
// cordic_pkg
// Shared definitions for the parameterised CORDIC cosine unit:
//   - state_t         : controller states (IDLE, BUSY, DONE)
//   - NAN_RESULT      : quiet-NaN word returned for out-of-range angles
//   - cordic_k()      : CORDIC gain compensation constant for a given WL
//   - atan_fixed()    : atan(2^-i) scaled by 2^frac, i = 0..27
//   - float_to_fixed(): IEEE-754 single magnitude -> Q1.frac
//   - fixed_to_float(): sign/magnitude Q1.frac -> IEEE-754 single
// Configuration macro: CORDIC_INPUT_ROUND_EN selects round-half-up in
// float_to_fixed(); without it the conversion truncates.
// ---------------------------------------------------------------------------
package cordic_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [31:0] NAN_RESULT  = 32'h7FC0_0000;
   localparam int          ANG_ENTRIES = 32;

   // Gain compensation 0.607252935 scaled to Q1.(wl-2), rounded to nearest,
   // done entirely in integer arithmetic so it folds at elaboration.
   function automatic longint cordic_k(input int wl);
      longint scaled;
      scaled = longint'(607252935) <<< (wl - 2);
      return (scaled + longint'(500000000)) / longint'(1000000000);
   endfunction

   // atan(2^-i) in radians; only ever evaluated with constant arguments.
   function automatic real atan_real(input int i);
      case (i)
         0:  return 0.7853981633974483;
         1:  return 0.4636476090008061;
         2:  return 0.24497866312686414;
         3:  return 0.12435499454676144;
         4:  return 0.06241880999595735;
         5:  return 0.031239833430268277;
         6:  return 0.015623728620476831;
         7:  return 0.007812341060101111;
         8:  return 0.0039062301319669718;
         9:  return 0.0019531225164788188;
         10: return 0.0009765621895593195;
         11: return 0.0004882812111948983;
         12: return 0.00024414062014936177;
         13: return 0.00012207031189367021;
         14: return 0.00006103515617420877;
         15: return 0.000030517578115526096;
         16: return 0.000015258789061315762;
         17: return 0.00000762939453110197;
         18: return 0.000003814697265606496;
         19: return 0.000001907348632810187;
         20: return 0.0000009536743164059608;
         21: return 0.00000047683715820308884;
         22: return 0.00000023841857910155797;
         23: return 0.00000011920928955078068;
         24: return 0.00000005960464477539055;
         25: return 0.000000029802322387695303;
         26: return 0.000000014901161193847655;
         27: return 0.000000007450580596923828;
         default: return 0.0;
      endcase
   endfunction

   // atan(2^-i) * 2^frac rounded to nearest; entries past 27 are zero.
   function automatic longint atan_fixed(input int i, input int frac);
      real scale;
      scale = 1.0;
      for (int k = 0; k < frac; k++) begin
         scale = scale * 2.0;
      end
      return longint'($rtoi(atan_real(i) * scale + 0.5));
   endfunction

   // |f| as an unsigned Q1.frac magnitude. The sign bit is ignored because
   // cosine is even. Exponents below 127-frac underflow to zero, and
   // out-of-range exponents (>= 128) also return zero since the caller
   // flags those separately. A 56-bit window lets one right shift cover
   // every legal exponent for frac up to 26.
   function automatic logic [31:0] float_to_fixed(input logic [31:0] f,
                                                  input int frac);
      int          expo;
      int          rsh;
      logic [55:0] full;
      logic [55:0] shifted;
      logic [55:0] limit;
      expo  = int'(f[30:23]);
      full  = {1'b1, f[22:0], 32'd0};
      limit = (56'd1 << (frac + 1)) - 56'd1;
      if (expo < 127 - frac || expo >= 128) begin
         return 32'd0;
      end
      rsh     = 55 - (expo - 127 + frac);
      shifted = full >> rsh;
`ifdef CORDIC_INPUT_ROUND_EN
      shifted = shifted + 56'(full[rsh - 1]);
      if (shifted > limit) begin
         shifted = limit;
      end
`else
      if (shifted > limit) begin
         shifted = limit;
      end
`endif
      return shifted[31:0];
   endfunction

   // Sign/magnitude Q1.frac to IEEE single. The leading one is moved to
   // bit 31 so the mantissa is the next 23 bits; lower bits are dropped.
   function automatic logic [31:0] fixed_to_float(input logic        sgn,
                                                  input logic [31:0] mag,
                                                  input int          frac);
      int          msb;
      logic [31:0] norm;
      logic [7:0]  expo;
      if (mag == 32'd0) begin
         return 32'd0;
      end
      msb = 0;
      for (int b = 0; b < 32; b++) begin
         if (mag[b]) begin
            msb = b;
         end
      end
      norm = mag << (31 - msb);
      expo = 8'(127 - (frac - msb));
      return {sgn, expo, norm[30:8]};
   endfunction

endpackage

// File: rtl/cordic_cos_param_stage.sv
// ---------------------------------------------------------------------------
// cordic_stage
// One combinational CORDIC rotation in rotation mode. The direction comes
// from the sign of the residual angle z; shifts are arithmetic so negative
// x/y stay correct.
// Ports:
//   x, y, z          : current vector and residual angle (signed Q1.(WL-2))
//   i                : rotation index (shift amount)
//   angle            : atan(2^-i) in the same fixed-point format
//   x_next, y_next,
//   z_next           : rotated vector and updated residual angle
// ---------------------------------------------------------------------------
module cordic_stage
   import cordic_pkg::*;
#(
   parameter int WL = 22
) (
   input  logic signed [WL-1:0] x,
   input  logic signed [WL-1:0] y,
   input  logic signed [WL-1:0] z,
   input  logic        [4:0]    i,
   input  logic signed [WL-1:0] angle,
   output logic signed [WL-1:0] x_next,
   output logic signed [WL-1:0] y_next,
   output logic signed [WL-1:0] z_next
);

   // Rotate toward z = 0: a non-negative residual rotates forward,
   // a negative residual rotates back.
   always_comb begin
      if (!z[WL-1]) begin
         x_next = x - (y >>> i);
         y_next = y + (x >>> i);
         z_next = z - angle;
      end else begin
         x_next = x + (y >>> i);
         y_next = y - (x >>> i);
         z_next = z + angle;
      end
   end

endmodule

// File: rtl/cordic_cos_param.sv
// ---------------------------------------------------------------------------
// cordic_cos_param
// Iterative CORDIC cosine with IEEE-754 single in/out. UNROLL rotations are
// applied per enabled clock, so a result takes ITER/UNROLL enabled cycles.
// Parameters: WL (word length, Q1.(WL-2)), ITER (rotations), UNROLL (1/2/4).
// Ports:
//   clock   : rising-edge clock
//   aclr    : synchronous active-high reset, wins over clk_en
//   clk_en  : all state advances only while high
//   start   : begin a computation (accepted in IDLE or DONE)
//   dataa   : angle in radians (IEEE single, sign ignored)
//   result  : cos(|dataa|) as IEEE single, held until the next done
//   done    : result valid
//   busy    : rotations in progress
//   err     : |dataa| >= 2, Inf or NaN; result is then quiet NaN
// Configuration macro: CORDIC_INPUT_ROUND_EN (round-half-up on input
// conversion instead of truncation; latency is identical).
// ---------------------------------------------------------------------------
module cordic_cos_param
   import cordic_pkg::*;
#(
   parameter int WL     = 22,
   parameter int ITER   = 16,
   parameter int UNROLL = 1
) (
   input  logic        clock,
   input  logic        aclr,
   input  logic        clk_en,
   input  logic        start,
   input  logic [31:0] dataa,
   output logic [31:0] result,
   output logic        done,
   output logic        busy,
   output logic        err
);

   localparam int                   FRAC   = WL - 2;
   localparam logic signed [WL-1:0] K_INIT = WL'(cordic_k(WL));

   if (WL < 16 || WL > 28) begin : g_bad_wl
      $error("cordic_cos_param: WL must be in 16..28");
   end
   if (ITER < 8 || ITER > WL - 2) begin : g_bad_iter
      $error("cordic_cos_param: ITER must be in 8..WL-2");
   end
   if ((UNROLL != 1 && UNROLL != 2 && UNROLL != 4) || (ITER % UNROLL) != 0) begin : g_bad_unroll
      $error("cordic_cos_param: UNROLL must be 1, 2 or 4 and divide ITER");
   end

   state_t                state;
   logic signed [WL-1:0]  x_q;
   logic signed [WL-1:0]  y_q;
   logic signed [WL-1:0]  z_q;
   logic        [4:0]     i_q;

   logic signed [WL-1:0]  x_fin;
   logic signed [WL-1:0]  y_fin;
   logic signed [WL-1:0]  z_fin;
   logic signed [WL-1:0]  x_abs;
   logic signed [WL-1:0]  z_load;
   logic                  in_err;
   logic                  last_step;
   logic        [31:0]    fin_word;

   logic signed [WL-1:0]  atan_rom [ANG_ENTRIES];

   // The angle table is padded to 32 entries so the 5-bit rotation index
   // addresses it directly; entries at or beyond ITER are never selected.
   for (genvar g = 0; g < ANG_ENTRIES; g++) begin : g_rom
      localparam logic signed [WL-1:0] ANG = WL'(atan_fixed(g, FRAC));
      assign atan_rom[g] = ANG;
   end

   // Chain of UNROLL rotations. Each stage works on index i_q + u, and the
   // last stage's outputs are what the registers load each BUSY cycle.
   for (genvar u = 0; u < UNROLL; u++) begin : g_stage
      logic signed [WL-1:0] xi;
      logic signed [WL-1:0] yi;
      logic signed [WL-1:0] zi;
      logic signed [WL-1:0] xo;
      logic signed [WL-1:0] yo;
      logic signed [WL-1:0] zo;
      logic        [4:0]    idx;

      if (u == 0) begin : g_head
         assign xi = x_q;
         assign yi = y_q;
         assign zi = z_q;
      end else begin : g_link
         assign xi = g_stage[u-1].xo;
         assign yi = g_stage[u-1].yo;
         assign zi = g_stage[u-1].zo;
      end

      assign idx = i_q + 5'(u);

      cordic_stage #(
         .WL(WL)
      ) u_stage (
         .x      (xi),
         .y      (yi),
         .z      (zi),
         .i      (idx),
         .angle  (atan_rom[idx]),
         .x_next (xo),
         .y_next (yo),
         .z_next (zo)
      );

      if (u == UNROLL - 1) begin : g_tail
         assign x_fin = xo;
         assign y_fin = yo;
         assign z_fin = zo;
      end
   end

   // Input check and conversion happen combinationally so an accepted
   // request loads z and err on the same edge. The final word is built
   // from the last stage's x so result lands together with done.
   always_comb begin
      in_err    = dataa[30];
      z_load    = WL'(float_to_fixed(dataa, FRAC));
      last_step = (i_q == 5'(ITER - UNROLL));
      x_abs     = x_fin[WL-1] ? -x_fin : x_fin;
      if (err) begin
         fin_word = NAN_RESULT;
      end else begin
         fin_word = fixed_to_float(x_fin[WL-1], {{(32 - WL){1'b0}}, x_abs}, FRAC);
      end
   end

   // Controller and datapath registers. Reset takes priority over clk_en;
   // start is only honoured outside BUSY so an in-flight rotation is never
   // disturbed. done and busy are mutually exclusive by construction.
   always_ff @(posedge clock) begin
      if (aclr) begin
         state  <= IDLE;
         done   <= 1'b0;
         busy   <= 1'b0;
         err    <= 1'b0;
         x_q    <= K_INIT;
         y_q    <= '0;
         z_q    <= '0;
         i_q    <= '0;
         result <= 32'd0;
      end else if (clk_en) begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state <= BUSY;
                  busy  <= 1'b1;
                  done  <= 1'b0;
                  err   <= in_err;
                  x_q   <= K_INIT;
                  y_q   <= '0;
                  z_q   <= in_err ? '0 : z_load;
                  i_q   <= '0;
               end
            end
            BUSY: begin
               x_q <= x_fin;
               y_q <= y_fin;
               z_q <= z_fin;
               i_q <= i_q + 5'(UNROLL);
               if (last_step) begin
                  state  <= DONE;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  result <= fin_word;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_cos_param.sv
// ---------------------------------------------------------------------------
// tb_cordic_cos_param
// Self-checking bench for cordic_cos_param. A default instance (UNROLL=1)
// carries most checks; UNROLL=2 and UNROLL=4 instances share its inputs to
// check latency scaling. Expected results come from real-valued cosine of
// the decoded input angle.
// ---------------------------------------------------------------------------
module tb_cordic_cos_param;

   localparam real TOL   = 1.0 / 16384.0;
   localparam int  LIMIT = 200;

   logic        clock = 1'b0;
   logic        aclr;
   logic        clk_en;
   logic        start;
   logic [31:0] dataa;
   logic [31:0] result, result2, result4;
   logic        done, busy, err;
   logic        done2, busy2, err2;
   logic        done4, busy4, err4;

   int num_checks = 0;
   int num_fails  = 0;
   int overlap    = 0;
   int lat2, lat4;

   always #5 clock = ~clock;

   cordic_cos_param #(.WL(22), .ITER(16), .UNROLL(1)) u_dut (
      .clock(clock), .aclr(aclr), .clk_en(clk_en), .start(start), .dataa(dataa),
      .result(result), .done(done), .busy(busy), .err(err)
   );

   cordic_cos_param #(.WL(22), .ITER(16), .UNROLL(2)) u_dut2 (
      .clock(clock), .aclr(aclr), .clk_en(clk_en), .start(start), .dataa(dataa),
      .result(result2), .done(done2), .busy(busy2), .err(err2)
   );

   cordic_cos_param #(.WL(22), .ITER(16), .UNROLL(4)) u_dut4 (
      .clock(clock), .aclr(aclr), .clk_en(clk_en), .start(start), .dataa(dataa),
      .result(result4), .done(done4), .busy(busy4), .err(err4)
   );

   // IEEE single -> real using plain arithmetic (no conversion builtins).
   function automatic real singleToReal(input logic [31:0] b);
      real v;
      int  e;
      if (b[30:0] == 31'd0) return 0.0;
      v = 1.0 + real'(b[22:0]) / 8388608.0;
      e = int'(b[30:23]) - 127;
      while (e > 0) begin v = v * 2.0; e--; end
      while (e < 0) begin v = v / 2.0; e++; end
      return b[31] ? -v : v;
   endfunction

   // real -> IEEE single (truncating mantissa), for values of modest size.
   function automatic logic [31:0] realToSingle(input real v);
      logic s;
      int   e;
      real  m;
      if (v == 0.0) return 32'd0;
      s = (v < 0.0);
      m = s ? -v : v;
      e = 127;
      while (m >= 2.0) begin m = m / 2.0; e++; end
      while (m < 1.0)  begin m = m * 2.0; e--; end
      return {s, 8'(e), 23'($rtoi((m - 1.0) * 8388608.0))};
   endfunction

   // Reference model: cos of the magnitude of the encoded angle.
   function automatic logic [31:0] cosExpected(input logic [31:0] angle);
      real a;
      a = singleToReal(angle);
      if (a < 0.0) a = -a;
      return realToSingle($cos(a));
   endfunction

   // tol == 0 means bit-exact; otherwise both words are compared as values.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected, input real tol);
      real diff;
      num_checks++;
      if (tol == 0.0) begin
         if (observed !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
         end
      end else begin
         diff = singleToReal(observed) - singleToReal(expected);
         if (diff < 0.0) diff = -diff;
         if ($isunknown(observed) || diff > tol) begin
            num_fails++;
            $display("[TB] FAIL %s: got 0x%08h (%f), expected 0x%08h (%f) within %g",
                     tag, observed, singleToReal(observed), expected,
                     singleToReal(expected), tol);
         end
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      if ((done && busy) || (done2 && busy2) || (done4 && busy4)) overlap++;
   endtask

   task automatic waitDone(inout int cycles);
      while (!done && cycles < LIMIT) begin
         tick();
         cycles++;
         if (done2 && lat2 < 0) lat2 = cycles;
         if (done4 && lat4 < 0) lat4 = cycles;
      end
   endtask

   task automatic applyStimulus(input logic [31:0] angle, output int cycles);
      dataa = angle;
      start = 1'b1;
      tick();
      start = 1'b0;
      cycles = 0;
      lat2 = -1;
      lat4 = -1;
      waitDone(cycles);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int          cycles;
      int          done_seen;
      logic [31:0] angle;
      logic [31:0] other;
      logic        err_exp;

      aclr   = 1'b1;
      clk_en = 1'b0;
      start  = 1'b0;
      dataa  = 32'd0;
      tick();
      tick();
      checkOutput("rst-done",   {31'd0, done}, 32'd0, 0.0);
      checkOutput("rst-busy",   {31'd0, busy}, 32'd0, 0.0);
      checkOutput("rst-err",    {31'd0, err},  32'd0, 0.0);
      checkOutput("rst-result", result,        32'd0, 0.0);
      aclr   = 1'b0;
      clk_en = 1'b1;
      tick();

      applyStimulus(32'h0000_0000, cycles);
      checkOutput("zero-lat", 32'(cycles), 32'd16, 0.0);
      checkOutput("zero-err", {31'd0, err}, 32'd0, 0.0);
      checkOutput("zero-cos", result, 32'h3F80_0000, TOL);

      applyStimulus(32'h3F80_0000, cycles);
      checkOutput("one-lat",  32'(cycles), 32'd16, 0.0);
      checkOutput("one-lat2", 32'(lat2),   32'd8,  0.0);
      checkOutput("one-lat4", 32'(lat4),   32'd4,  0.0);
      checkOutput("one-cos",  result,  32'h3F0A_5140, TOL);
      checkOutput("one-cos2", result2, cosExpected(32'h3F80_0000), TOL);
      checkOutput("one-cos4", result4, cosExpected(32'h3F80_0000), TOL);
      repeat (4) tick();
      checkOutput("one-hold", result, cosExpected(32'h3F80_0000), TOL);
      checkOutput("one-done-hold", {31'd0, done}, 32'd1, 0.0);

      applyStimulus(32'hBFD9_999A, cycles);
      checkOutput("neg-lat",  32'(cycles), 32'd16, 0.0);
      checkOutput("neg-cos",  result, cosExpected(32'hBFD9_999A), TOL);
      checkOutput("neg-sign", {31'd0, result[31]}, 32'd1, 0.0);

      applyStimulus(32'h4000_0000, cycles);
      checkOutput("two-lat", 32'(cycles), 32'd16, 0.0);
      checkOutput("two-err", {31'd0, err}, 32'd1, 0.0);
      checkOutput("two-nan", result, 32'h7FC0_0000, 0.0);

      angle = realToSingle(0.3);
      other = realToSingle(1.2);
      dataa = angle;
      start = 1'b1;
      tick();
      start = 1'b0;
      cycles = 0;
      lat2 = -1;
      lat4 = -1;
      checkOutput("acc-busy", {31'd0, busy}, 32'd1, 0.0);
      checkOutput("acc-done", {31'd0, done}, 32'd0, 0.0);
      repeat (5) begin tick(); cycles++; end
      dataa = other;
      start = 1'b1;
      tick();
      cycles++;
      start = 1'b0;
      waitDone(cycles);
      checkOutput("ign-lat", 32'(cycles), 32'd16, 0.0);
      checkOutput("ign-cos", result, cosExpected(angle), TOL);

      angle = realToSingle(0.8);
      dataa = angle;
      start = 1'b1;
      tick();
      start = 1'b0;
      checkOutput("redo-done-drop", {31'd0, done}, 32'd0, 0.0);
      checkOutput("redo-busy",      {31'd0, busy}, 32'd1, 0.0);
      cycles = 0;
      waitDone(cycles);
      checkOutput("redo-lat", 32'(cycles), 32'd16, 0.0);
      checkOutput("redo-cos", result, cosExpected(angle), TOL);

      angle = realToSingle(1.45);
      dataa = angle;
      start = 1'b1;
      tick();
      start = 1'b0;
      cycles = 0;
      repeat (4) begin tick(); cycles++; end
      clk_en = 1'b0;
      repeat (3) begin tick(); cycles++; end
      checkOutput("gap-busy", {31'd0, busy}, 32'd1, 0.0);
      clk_en = 1'b1;
      waitDone(cycles);
      checkOutput("gap-lat", 32'(cycles), 32'd19, 0.0);
      checkOutput("gap-cos", result, cosExpected(angle), TOL);

      applyStimulus(32'h3F7F_FFFF, cycles);
      checkOutput("near1-lat", 32'(cycles), 32'd16, 0.0);
      checkOutput("near1-cos", result, cosExpected(32'h3F7F_FFFF), TOL);

      dataa = realToSingle(0.5);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (7) tick();
      aclr = 1'b1;
      tick();
      aclr = 1'b0;
      checkOutput("abort-busy",   {31'd0, busy}, 32'd0, 0.0);
      checkOutput("abort-done",   {31'd0, done}, 32'd0, 0.0);
      checkOutput("abort-err",    {31'd0, err},  32'd0, 0.0);
      checkOutput("abort-result", result,        32'd0, 0.0);
      done_seen = 0;
      repeat (30) begin
         tick();
         if (done) done_seen++;
      end
      checkOutput("abort-no-done", 32'(done_seen), 32'd0, 0.0);

      for (int n = 0; n < 24; n++) begin
         if ($urandom_range(0, 7) == 0) begin
            angle = {1'($urandom), 8'($urandom_range(128, 255)), 23'($urandom)};
         end else begin
            angle = realToSingle(real'($urandom_range(0, 1700000)) / 1.0e6)
                    | {1'($urandom), 31'd0};
         end
         err_exp = (angle[30:23] >= 8'd128);
         applyStimulus(angle, cycles);
         checkOutput("rnd-lat", 32'(cycles), 32'd16, 0.0);
         checkOutput("rnd-err", {31'd0, err}, {31'd0, err_exp}, 0.0);
         if (err_exp) begin
            checkOutput("rnd-nan", result, 32'h7FC0_0000, 0.0);
         end else begin
            checkOutput("rnd-cos", result, cosExpected(angle), TOL);
         end
      end

      checkOutput("done-busy-excl", 32'(overlap), 32'd0, 0.0);

      $display("== %0d vectors applied, %0d miscompares ==", num_checks, num_fails);
      $finish;
   end

endmodule
